// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the instr_sequencer block.
//   seq_state_t : sequencer phase encoding (IDLE, FETCH, EXEC, MEM, HALT)
//   PC_W_DEF    : default program-counter width
//   JPTR_W_DEF  : default branch LUT index width
//   WAIT_W      : width of the data-memory wait counter (MEM_LAT up to 15)
//   is_busy()   : true for the phases that belong to a running instruction
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int PC_W_DEF   = 10;
    localparam int JPTR_W_DEF = 6;
    localparam int WAIT_W     = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    function automatic logic is_busy(input seq_state_t s);
        return (s == FETCH) || (s == EXEC) || (s == MEM);
    endfunction

endpackage

// File: rtl/jump_lut.sv
// ---------------------------------------------------------------------------
// jump_lut
// Combinational branch-target table. The decoder's Jptr field selects one of
// the program's branch labels; the entry is the absolute PC of that label.
// Entries are written as 10-bit constants and resized to PC_W (zero-extended
// when PC_W is wider). Unlisted indices resolve to PC 0.
// Ports:
//   jptr_i   [JPTR_W-1:0]  in   branch label index
//   target_o [PC_W-1:0]    out  branch target PC
// ---------------------------------------------------------------------------
module jump_lut
    import seq_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int JPTR_W = JPTR_W_DEF
) (
    input  logic [JPTR_W-1:0] jptr_i,
    output logic [PC_W-1:0]   target_o
);

    // One arm per branch label of the resident program.
    always_comb begin
        target_o = '0;
        case (jptr_i)
            JPTR_W'(1):  target_o = PC_W'(10'h010);
            JPTR_W'(2):  target_o = PC_W'(10'h100);
            JPTR_W'(5):  target_o = PC_W'(10'h020);
            JPTR_W'(9):  target_o = PC_W'(10'h3FF);
            JPTR_W'(17): target_o = PC_W'(10'h155);
            JPTR_W'(63): target_o = PC_W'(10'h2AA);
            default:     target_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle control sequencer for the 9-bit single-issue core. Owns the
// program counter, walks each instruction through FETCH -> EXEC [-> MEM...],
// gates the decoder's raw write enables so each fires once per instruction,
// resolves taken branches through jump_lut and reports halt via Ack.
//
// Optional feature: define SEQ_PERF_CNT_EN to add the Cyc_cnt / Instr_cnt
// performance counters. Without it the ports and counters do not exist.
//
// Start/Ack handshake: Start is a request that is accepted only on an edge
// where the sequencer is in IDLE or HALT; at any other time it is ignored.
// Ack is high for exactly as long as the sequencer sits in HALT and drops on
// the same edge that accepts a new Start.
//
// Ports:
//   Clk, Reset          in   clock; synchronous active-high reset
//   Start               in   launch program from PC 0
//   Jen, Jptr, Taken    in   branch flag, branch LUT index, ALU condition
//   RenD, WenD          in   decoder load / store flags
//   WenR                in   decoder raw register-write enable
//   Done                in   decoder halt flag
//   Prog_ctr [PC_W]     out  instruction memory address
//   InstrEn             out  latch instruction register (FETCH)
//   WenR_q, WenD_q      out  gated register-file / data-memory writes
//   Busy                out  FETCH, EXEC or MEM
//   Ack                 out  program halted
//   dbg_state_o         out  current sequencer phase, for observation
//   Cyc_cnt, Instr_cnt  out  (SEQ_PERF_CNT_EN only) saturating counters
// ---------------------------------------------------------------------------
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int JPTR_W  = JPTR_W_DEF,
    parameter int MEM_LAT = 2            // legal range 1..15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Jen,
    input  logic [JPTR_W-1:0] Jptr,
    input  logic              Taken,
    input  logic              RenD,
    input  logic              WenD,
    input  logic              WenR,
    input  logic              Done,
    output logic [PC_W-1:0]   Prog_ctr,
    output logic              InstrEn,
    output logic              WenR_q,
    output logic              WenD_q,
    output logic              Busy,
    output logic              Ack,
    output seq_state_t        dbg_state_o
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       Cyc_cnt,
    output logic [31:0]       Instr_cnt
`endif
);

    // Wait-counter value loaded on entry to MEM; the counter runs down to 0,
    // so MEM_LAST marks the first MEM cycle and 0 marks the last one.
    localparam logic [WAIT_W-1:0] MEM_LAST = WAIT_W'(MEM_LAT - 1);

    seq_state_t        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              wenr_gate;
    logic              wend_gate;
    logic [PC_W-1:0]   lut_target;

    jump_lut #(
        .PC_W   (PC_W),
        .JPTR_W (JPTR_W)
    ) u_jump_lut (
        .jptr_i   (Jptr),
        .target_o (lut_target)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wait_q  <= wait_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state, PC update and write-enable gating
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wait_d    = wait_q;
        wenr_gate = 1'b0;
        wend_gate = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                state_d = EXEC;
            end

            EXEC: begin
                if (Done) begin
                    // Halt instruction: PC stays on it, nothing is written.
                    state_d = HALT;
                end else if (RenD || WenD) begin
                    // Memory access takes priority over any branch flag;
                    // the register write (for loads) is deferred to the
                    // last MEM cycle when the read data is available.
                    state_d = MEM;
                    wait_d  = MEM_LAST;
                end else begin
                    wenr_gate = WenR;
                    if (Jen && Taken) begin
                        pc_d = lut_target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                    state_d = FETCH;
                end
            end

            MEM: begin
                if (wait_q == MEM_LAST) begin
                    wend_gate = WenD;
                end
                if (wait_q == '0) begin
                    wenr_gate = WenR;
                    pc_d      = pc_q + PC_W'(1);
                    state_d   = FETCH;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            HALT: begin
                if (Start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: decodes of the registered state plus the gated enables
    // -----------------------------------------------------------------------
    assign Prog_ctr    = pc_q;
    assign InstrEn     = (state_q == FETCH);
    assign Busy        = is_busy(state_q);
    assign Ack         = (state_q == HALT);
    assign WenR_q      = wenr_gate;
    assign WenD_q      = wend_gate;
    assign dbg_state_o = state_q;

`ifdef SEQ_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Performance counters: cleared by reset and by an accepted Start,
    // saturating at all-ones.
    // -----------------------------------------------------------------------
    logic [31:0] cyc_cnt_q;
    logic [31:0] instr_cnt_q;
    logic        start_accept;

    assign start_accept = Start && ((state_q == IDLE) || (state_q == HALT));

    always_ff @(posedge Clk) begin
        if (Reset || start_accept) begin
            cyc_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (Busy && (cyc_cnt_q != '1)) begin
                cyc_cnt_q <= cyc_cnt_q + 32'd1;
            end
            if ((state_q == EXEC) && (instr_cnt_q != '1)) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
        end
    end

    assign Cyc_cnt   = cyc_cnt_q;
    assign Instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Self-checking bench for instr_sequencer. The bench plays the decoder: for
// every instruction it holds the decoder fields from EXEC onward and drives
// random junk during FETCH (and random Start while busy, which must be
// ignored). An instruction-level reference model turns each instruction into
// its per-cycle expected outputs {Prog_ctr, InstrEn, WenR_q, WenD_q, Busy,
// Ack}; observed samples are compared against that queue.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int PC_W    = 10;
    localparam int JPTR_W  = 6;
    localparam int MEM_LAT = 2;
    localparam int W       = 15;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic              Jen;
    logic [JPTR_W-1:0] Jptr;
    logic              Taken;
    logic              RenD;
    logic              WenD;
    logic              WenR;
    logic              Done;
    logic [PC_W-1:0]   Prog_ctr;
    logic              InstrEn;
    logic              WenR_q;
    logic              WenD_q;
    logic              Busy;
    logic              Ack;
    seq_pkg::seq_state_t dbg_state;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]       Cyc_cnt;
    logic [31:0]       Instr_cnt;
`endif

    instr_sequencer #(
        .PC_W    (PC_W),
        .JPTR_W  (JPTR_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Jen         (Jen),
        .Jptr        (Jptr),
        .Taken       (Taken),
        .RenD        (RenD),
        .WenD        (WenD),
        .WenR        (WenR),
        .Done        (Done),
        .Prog_ctr    (Prog_ctr),
        .InstrEn     (InstrEn),
        .WenR_q      (WenR_q),
        .WenD_q      (WenD_q),
        .Busy        (Busy),
        .Ack         (Ack),
        .dbg_state_o (dbg_state)
`ifdef SEQ_PERF_CNT_EN
        ,
        .Cyc_cnt     (Cyc_cnt),
        .Instr_cnt   (Instr_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- bench state ----------------
    typedef struct packed {
        logic       jen;
        logic [5:0] jptr;
        logic       taken;
        logic       rend;
        logic       wend;
        logic       wenr;
        logic       done;
    } instr_t;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [9:0]   m_pc = '0;
    bit           m_halted = 1'b0;
    int           m_cyc = 0;
    int           m_ins = 0;
    bit           hold_start = 1'b0;
    int           reset_at = -1;

    // Branch targets of the resident program.
    function automatic logic [9:0] ref_lut(input logic [5:0] idx);
        case (idx)
            6'd1:    return 10'h010;
            6'd2:    return 10'h100;
            6'd5:    return 10'h020;
            6'd9:    return 10'h3FF;
            6'd17:   return 10'h155;
            6'd63:   return 10'h2AA;
            default: return 10'h000;
        endcase
    endfunction

    function automatic logic [W-1:0] pack(input logic [9:0] pc, input logic ie,
                                          input logic wr, input logic wd,
                                          input logic bz, input logic ak);
        return {pc, ie, wr, wd, bz, ak};
    endfunction

    function automatic logic [W-1:0] sample();
        return {Prog_ctr, InstrEn, WenR_q, WenD_q, Busy, Ack};
    endfunction

    function automatic instr_t mk(input logic jen, input logic [5:0] jptr,
                                  input logic taken, input logic rend,
                                  input logic wend, input logic wenr,
                                  input logic done);
        instr_t r;
        r.jen = jen; r.jptr = jptr; r.taken = taken; r.rend = rend;
        r.wend = wend; r.wenr = wenr; r.done = done;
        return r;
    endfunction

    function automatic instr_t rand_instr();
        int         k;
        logic [5:0] jp;
        logic       wr;
        logic       tk;
        logic       rd;
        k  = $urandom_range(0, 19);
        wr = 1'($urandom_range(0, 1));
        tk = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 6))
            0:       jp = 6'd1;
            1:       jp = 6'd2;
            2:       jp = 6'd5;
            3:       jp = 6'd9;
            4:       jp = 6'd17;
            5:       jp = 6'd63;
            default: jp = 6'($urandom);
        endcase
        if (k < 8)       return mk(1'b0, jp, tk, 1'b0, 1'b0, wr, 1'b0); // ALU
        else if (k < 12) return mk(1'b1, jp, tk, 1'b0, 1'b0, wr, 1'b0); // branch
        else if (k < 15) return mk(1'b0, jp, tk, 1'b1, 1'b0, wr, 1'b0); // load
        else if (k < 17) return mk(1'b0, jp, tk, 1'b0, 1'b1, wr, 1'b0); // store
        else if (k < 19) return mk(1'b1, jp, 1'b1, rd, ~rd, wr, 1'b0);  // mem + stray branch
        else             return mk(1'b0, jp, tk, rd, 1'b0, wr, 1'b1);   // halt
    endfunction

    // ---------------- reference model ----------------
    task automatic model_instr(input instr_t i, output int n);
        exp_q.push_back(pack(m_pc, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        if (i.done) begin
            exp_q.push_back(pack(m_pc, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            m_halted = 1'b1;
            n = 2;
        end else if (i.rend || i.wend) begin
            exp_q.push_back(pack(m_pc, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            for (int k = 0; k < MEM_LAT; k++)
                exp_q.push_back(pack(m_pc, 1'b0, (k == MEM_LAT - 1) && i.wenr,
                                     (k == 0) && i.wend, 1'b1, 1'b0));
            m_pc = m_pc + 10'd1;
            n = 2 + MEM_LAT;
        end else begin
            exp_q.push_back(pack(m_pc, 1'b0, i.wenr, 1'b0, 1'b1, 1'b0));
            m_pc = (i.jen && i.taken) ? ref_lut(i.jptr) : m_pc + 10'd1;
            n = 2;
        end
        m_cyc += n;
        m_ins += 1;
    endtask

    task automatic model_idle(input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back(pack(m_pc, 1'b0, 1'b0, 1'b0, 1'b0, m_halted));
    endtask

    task automatic model_start();
        exp_q.push_back(pack(m_pc, 1'b0, 1'b0, 1'b0, 1'b0, m_halted));
        m_pc = '0; m_halted = 1'b0; m_cyc = 0; m_ins = 0;
    endtask

    task automatic model_reset();
        m_pc = '0; m_halted = 1'b0; m_cyc = 0; m_ins = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_junk();
        Jen   = 1'($urandom_range(0, 1));
        Jptr  = 6'($urandom);
        Taken = 1'($urandom_range(0, 1));
        RenD  = 1'($urandom_range(0, 1));
        WenD  = 1'($urandom_range(0, 1));
        WenR  = 1'($urandom_range(0, 1));
        Done  = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_fields(input instr_t i);
        Jen = i.jen; Jptr = i.jptr; Taken = i.taken; RenD = i.rend;
        WenD = i.wend; WenR = i.wenr; Done = i.done;
    endtask

    // Each cycle: drive just after the rising edge, sample 1 time unit later.
    task automatic drive_instr(input instr_t i, input int n);
        for (int c = 0; c < n; c++) begin
            if (c == 0) drive_junk();
            else        drive_fields(i);
            Start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
            Reset = (c == reset_at);
            #1;
            obs_q.push_back(sample());
            @(posedge Clk); #1;
        end
        Start = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            drive_junk();
            Start = 1'b0;
            #1;
            obs_q.push_back(sample());
            @(posedge Clk); #1;
        end
    endtask

    task automatic start_program();
        drive_junk();
        Start = 1'b1;
        #1;
        obs_q.push_back(sample());
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    // Reset cycle also asserts Start: reset must win.
    task automatic do_reset();
        drive_junk();
        Reset = 1'b1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        Start = 1'b0;
    endtask

    task automatic run(input instr_t i);
        int n;
        model_instr(i, n);
        drive_instr(i, n);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        model_reset();
        model_idle(3);
        idle_cycles(3);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL reset cycle %0d: got pc=%h ie,wr,wd,busy,ack=%b required pc=%h %b",
                         k, obs_q[k][14:5], obs_q[k][4:0], exp_q[k][14:5], exp_q[k][4:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++;
        if (dbg_state !== seq_pkg::IDLE) begin
            n_bad++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, seq_pkg::IDLE);
        end
    endtask

    task automatic test_alu();
        model_start();
        start_program();
        for (int k = 0; k < 3; k++) run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL alu cycle %0d: got pc=%h ie,wr,wd,busy,ack=%b required pc=%h %b",
                         k, obs_q[k][14:5], obs_q[k][4:0], exp_q[k][14:5], exp_q[k][4:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_branch();
        run(mk(1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));  // -> 0x020
        run(mk(1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));  // -> 0x021
        run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL branch cycle %0d: got pc=%h ie,wr,wd,busy,ack=%b required pc=%h %b",
                         k, obs_q[k][14:5], obs_q[k][4:0], exp_q[k][14:5], exp_q[k][4:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_load();
        do_reset(); model_reset();
        model_start(); start_program();
        for (int k = 0; k < 3; k++) run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        run(mk(1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));  // load at PC 3
        run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));  // at PC 4
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL load cycle %0d: got pc=%h ie,wr,wd,busy,ack=%b required pc=%h %b",
                         k, obs_q[k][14:5], obs_q[k][4:0], exp_q[k][14:5], exp_q[k][4:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_store();
        do_reset(); model_reset();
        model_start(); start_program();
        for (int k = 0; k < 3; k++) run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));  // store at PC 3
        run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL store cycle %0d: got pc=%h ie,wr,wd,busy,ack=%b required pc=%h %b",
                         k, obs_q[k][14:5], obs_q[k][4:0], exp_q[k][14:5], exp_q[k][4:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_done_restart();
        do_reset(); model_reset();
        model_start(); start_program();
        for (int k = 0; k < 7; k++) run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));  // Done at PC 7
        model_idle(3); idle_cycles(3);
        n_cmp++;
        if (dbg_state !== seq_pkg::HALT) begin
            n_bad++;
            $display("FAIL halt_state: got %0d required %0d", dbg_state, seq_pkg::HALT);
        end
        model_start(); start_program();
        hold_start = 1'b1;
        run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));  // Start held: ignored
        hold_start = 1'b0;
        run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL done cycle %0d: got pc=%h ie,wr,wd,busy,ack=%b required pc=%h %b",
                         k, obs_q[k][14:5], obs_q[k][4:0], exp_q[k][14:5], exp_q[k][4:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_mem();
        do_reset(); model_reset();
        model_start(); start_program();
        for (int k = 0; k < 3; k++) run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        // Store at PC 3 cut short by reset during its first MEM cycle.
        exp_q.push_back(pack(10'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(pack(10'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(pack(10'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        reset_at = 2;
        drive_instr(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 3);
        reset_at = -1;
        model_reset();
        model_idle(2); idle_cycles(2);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL rst_mem cycle %0d: got pc=%h ie,wr,wd,busy,ack=%b required pc=%h %b",
                         k, obs_q[k][14:5], obs_q[k][4:0], exp_q[k][14:5], exp_q[k][4:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_pc_wrap();
        model_start(); start_program();
        run(mk(1'b1, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));  // -> 0x3FF
        run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));  // -> 0x000
        run(mk(1'b1, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));  // -> 0x3FF
        run(mk(1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));  // load -> 0x000
        run(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL wrap cycle %0d: got pc=%h ie,wr,wd,busy,ack=%b required pc=%h %b",
                         k, obs_q[k][14:5], obs_q[k][4:0], exp_q[k][14:5], exp_q[k][4:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        for (int t = 0; t < 300; t++) begin
            instr_t ins;
            int     ni;
            ins = rand_instr();
            run(ins);
            if (ins.done) begin
                ni = $urandom_range(1, 3);
                model_idle(ni); idle_cycles(ni);
                model_start(); start_program();
            end
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL random cycle %0d: got pc=%h ie,wr,wd,busy,ack=%b required pc=%h %b",
                         k, obs_q[k][14:5], obs_q[k][4:0], exp_q[k][14:5], exp_q[k][4:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
`ifdef SEQ_PERF_CNT_EN
        n_cmp++;
        if (Cyc_cnt !== 32'(m_cyc)) begin
            n_bad++;
            $display("FAIL cyc_cnt: got %0d required %0d", Cyc_cnt, m_cyc);
        end
        n_cmp++;
        if (Instr_cnt !== 32'(m_ins)) begin
            n_bad++;
            $display("FAIL instr_cnt: got %0d required %0d", Instr_cnt, m_ins);
        end
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        drive_junk();
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_store();
        test_done_restart();
        test_reset_mid_mem();
        test_pc_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
